// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the forwarding register file.
// Default sizes, the hardwired-zero register index and address-width derivation.
package reg_file_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_RD   = 2;
    localparam int REG_ZERO     = 0;

    // A single-register file still needs a 1-bit address bus.
    function automatic int addr_w_f(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/reg_fwd_mux.sv
// Priority forwarding mux for one register address:
// zero/out-of-range, then same-cycle write, then buffered write, then array.
module reg_fwd_mux
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = addr_w_f(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              cur_en,
    input  logic [ADDR_W-1:0] cur_addr,
    input  logic [DATA_W-1:0] cur_data,
    input  logic              buf_valid,
    input  logic [ADDR_W-1:0] buf_addr,
    input  logic [DATA_W-1:0] buf_data,
    input  logic [DATA_W-1:0] arr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic addr_zero;

    // Out-of-range addresses must never expose array contents (or X).
    assign addr_zero = (addr == ADDR_W'(REG_ZERO)) || (32'(addr) >= NUM_REGS);

    always_comb begin
        rd_data = '0;
        if (addr_zero) begin
            rd_data = '0;
        end else if (cur_en && (cur_addr == addr)) begin
            rd_data = cur_data;
        end else if (buf_valid && (buf_addr == addr)) begin
            rd_data = buf_data;
        end else begin
            rd_data = arr_data;
        end
    end

endmodule

// File: rtl/reg_file_fwd.sv
// General-purpose register file with a one-entry write-back buffer and full
// read forwarding on every read port and on the architected-state view.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no buffered write; wr_ready=1
// ST_FULL  | buffer holds an uncommitted write (wb_busy=1)
module reg_file_fwd
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ADDR_W   = addr_w_f(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       wb_hold,
    output logic                       wb_busy,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_REGS*DATA_W-1:0] regs_view
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [DATA_W-1:0] arr_q [NUM_REGS];
    logic [DATA_W-1:0] arr_d [NUM_REGS];

    logic wb_valid;
    logic addr_ok;
    logic acc;
    logic commit;

    assign wb_valid = (state_q == ST_FULL);
    assign wr_ready = !wb_valid || !wb_hold;
    assign wb_busy  = wb_valid;

    // r0 and out-of-range writes handshake normally but are dropped.
    assign addr_ok = (wr_addr != ADDR_W'(REG_ZERO)) && (32'(wr_addr) < NUM_REGS);
    assign acc     = wr_en && wr_ready && addr_ok;
    assign commit  = wb_valid && !wb_hold;

    always_comb begin
        arr_d     = arr_q;
        state_d   = state_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;

        // Commit sees the old buffer; a same-address accept only refreshes the buffer.
        if (commit) begin
            arr_d[wb_addr_q] = wb_data_q;
        end

        case (state_q)
            ST_EMPTY: if (acc) state_d = ST_FULL;
            ST_FULL:  if (!acc && commit) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (acc) begin
            wb_addr_d = wr_addr;
            wb_data_d = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            arr_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            arr_q     <= arr_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] rd_a;
        assign rd_a = rd_addr[p*ADDR_W +: ADDR_W];

        reg_fwd_mux #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W)
        ) u_mux (
            .addr      (rd_a),
            .cur_en    (acc),
            .cur_addr  (wr_addr),
            .cur_data  (wr_data),
            .buf_valid (wb_valid),
            .buf_addr  (wb_addr_q),
            .buf_data  (wb_data_q),
            .arr_data  (arr_q[rd_a]),
            .rd_data   (rd_data[p*DATA_W +: DATA_W])
        );
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_view
        reg_fwd_mux #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W)
        ) u_mux (
            .addr      (ADDR_W'(r)),
            .cur_en    (acc),
            .cur_addr  (wr_addr),
            .cur_data  (wr_data),
            .buf_valid (wb_valid),
            .buf_addr  (wb_addr_q),
            .buf_data  (wb_data_q),
            .arr_data  (arr_q[r]),
            .rd_data   (regs_view[r*DATA_W +: DATA_W])
        );
    end

endmodule
